// File: rtl/gray_frame_arbiter_pkg.sv
// Shared definitions for the two-source frame arbiter: FSM states,
// source indices, default frame size and the round-robin winner helper.
package gray_frame_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  localparam int unsigned FRAME_PIXELS_DEF = 307200;

  // Prefer the source that did not own the previous frame; fall back to the other.
  function automatic logic pick_winner(input logic last_src,
                                       input logic req0,
                                       input logic req1);
    if (last_src == SRC1) begin
      return req0 ? SRC0 : SRC1;
    end
    return req1 ? SRC1 : SRC0;
  endfunction

endpackage

// File: rtl/gray_frame_arbiter.sv
// Frame-granular round-robin arbiter presenting two FWFT source FIFOs as a
// single FWFT FIFO to the grayscale stage. A granted source keeps ownership
// for FRAME_PIXELS transferred words, so frames are never interleaved.
module gray_frame_arbiter
  import gray_frame_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DATA_WIDTH = 32,
  parameter int unsigned FRAME_PIXELS    = FRAME_PIXELS_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  output logic                       src0_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0] src0_dout,
  input  logic                       src0_empty,
  output logic                       src1_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0] src1_dout,
  input  logic                       src1_empty,
  input  logic                       arb_rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] arb_dout,
  output logic                       arb_empty,
  output logic                       grant_valid,
  output logic                       grant_src,
  output logic                       frame_done
);

  localparam int unsigned CNT_W = $clog2(FRAME_PIXELS) + 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             last_src_q, last_src_d;
  logic             grant_valid_q, grant_valid_d;
  logic             grant_src_q, grant_src_d;
  logic             frame_done_q, frame_done_d;

  logic [FIFO_DATA_WIDTH-1:0] head_dout;
  logic                       head_empty;
  logic                       xfer;

  assign grant_valid = grant_valid_q;
  assign grant_src   = grant_src_q;
  assign frame_done  = frame_done_q;

  // State registers; async reset drops any partial frame without a done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pix_cnt_q     <= '0;
      last_src_q    <= SRC1;
      grant_valid_q <= 1'b0;
      grant_src_q   <= SRC0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      last_src_q    <= last_src_d;
      grant_valid_q <= grant_valid_d;
      grant_src_q   <= grant_src_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Read-side mux, source strobes and frame arbitration next-state.
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    last_src_d    = last_src_q;
    grant_valid_d = grant_valid_q;
    grant_src_d   = grant_src_q;
    frame_done_d  = 1'b0;

    head_dout  = (grant_src_q == SRC1) ? src1_dout  : src0_dout;
    head_empty = (grant_src_q == SRC1) ? src1_empty : src0_empty;

    arb_empty  = ~grant_valid_q | head_empty;
    arb_dout   = grant_valid_q ? head_dout : '0;
    xfer       = arb_rd_en & ~arb_empty;
    src0_rd_en = xfer & grant_valid_q & (grant_src_q == SRC0);
    src1_rd_en = xfer & grant_valid_q & (grant_src_q == SRC1);

    unique case (state_q)
      ST_IDLE: begin
        if (enable && (!src0_empty || !src1_empty)) begin
          state_d       = ST_GRANT;
          grant_valid_d = 1'b1;
          grant_src_d   = pick_winner(last_src_q, !src0_empty, !src1_empty);
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d     = '0;
            last_src_d    = grant_src_q;
            grant_valid_d = 1'b0;
            frame_done_d  = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
